vedic_mul_iter: RTL
===================

Name: vedic_mul_iter

Overview:
- Parametrised, iterative unsigned N x N Vedic multiplier with valid/ready handshakes on input and output.
- Reuses one combinational N/2 x N/2 Vedic core over four cycles, one partial product (Urdhva-Tiryagbhyam quadrant) per cycle, instead of instantiating four cores.
- Adds an optional approximate mode that drops the low quadrant product.
- Successor to the fixed 32x32 combinational multiplier; sits between operand producers and accumulate/datapath logic in the approximate-arithmetic blocks.

Parameters:
- N, 32: operand width. Power of two, 8..64; elaboration error otherwise.
- H, N/2: derived half width. Localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b/approx are valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  N  multiplicand, unsigned.
- b  in  N  multiplier, unsigned.
- approx  in  1  request approximate product; sampled with the operands.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out  out  2N  product.
- out_approx  out  1  echoes the approx bit latched with these operands.

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE, step=0, acc=0, out=0, out_valid=0, out_approx=0. in_ready=1 on the first cycle after reset deasserts.
- rst during CALC or DONE aborts the operation. The partial result is discarded and never emitted.
- States:
  - IDLE: in_ready=1.
  - CALC: step counter 0..3, in_ready=0.
  - DONE: out_valid=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready.
- Accept: on the edge where in_valid & in_ready, latch a, b, approx; set acc=0, step=0, state=CALC.
- CALC, one partial product per edge, split into AL/AH and BL/BH halves:
  - step0: acc += AL*BL. If the latched approx=1 and the feature is enabled, add 0 instead.
  - step1: acc += (AH*BL) << H.
  - step2: acc += (AL*BH) << H.
  - step3: acc += (AH*BH) << N. On this edge: out <= final acc, state=DONE.
- The core inputs are muxed from the latched halves by step. Accumulator is 2N bits and cannot overflow.
- Latency: accept at edge k; out_valid=1 after edge k+4. The approximate path keeps the same latency, since step0 still consumes its cycle.
- DONE: out and out_approx are held stable while out_valid & !out_ready, for unbounded backpressure.
- On out_valid & out_ready:
  - With in_valid=1 in the same cycle, the new operands are accepted and state goes to CALC. Peak throughput is 1 result per 5 cycles.
  - Otherwise state goes to IDLE.
- out_valid deasserts the cycle after the output handshake unless a new result completes. A new result cannot complete in that cycle, so out_valid always deasserts.
- in_valid is ignored when in_ready=0. Operand changes while busy have no effect.
- Results are bit-exact unsigned products in exact mode: a=b=2^N-1 gives out=2^2N - 2^(N+1) + 1.

Optional Feature:
- Macro: VEDIC_MUL_ITER_APPROX_EN.
- Defined: the approx input is honoured. An approximate result equals exact - AL*BL, so absolute error < 2^N. out_approx echoes the latched approx bit.
- Undefined: the approx input is ignored and the step0 quadrant is always added. out_approx is tied 0. The ports remain present in both builds.

Decomposition:
- Package vedic_mul_pkg:
  - state enum typedef (IDLE, CALC, DONE).
  - 2-bit step typedef and named step constants.
  - helper function returning the shift amount per step for a given H.
- Sub-module vedic_core_hxh, parameter W: purely combinational W x W -> 2W Vedic multiplier.
  - Built recursively from four W/2 cores down to a 2x2 leaf.
  - Instantiated once with W=H.

Test Plan (N=32 unless stated):
- Exact corner cases: a=0xFFFFFFFF, b=0xFFFFFFFF, approx=0 -> out=0xFFFFFFFE00000001, out_valid 4 edges after accept. a=0 with b=0x12345678 -> out=0.
- Approx mode (feature enabled): a=0x00010003, b=0x00020005, approx=1 -> out=0x2000B0000 and out_approx=1. The same operands with approx=0 -> out=0x2000B000F. With the feature undefined and approx=1 -> out=0x2000B000F, out_approx=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out, out_valid and out_approx stay constant and in_ready=0. Then raise out_ready together with a new in_valid -> new operands accepted in that same cycle, next result 5 cycles later.
- Reset mid-operation: assert rst at CALC step2 -> next cycle out_valid=0, out=0, in_ready=1. No stale result appears afterwards.
- Random regression: 200 random a/b pairs with approx=0 and random out_ready stalls. Every result equals a*b, in order, with no drops or duplicates. Repeat with N=8 and N=64.

Source files
------------

// File: rtl/vedic_mul_pkg.sv
// Shared types for the iterative Vedic multiplier: FSM states, step encoding
// and the per-step partial-product shift.
package vedic_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  localparam step_t STEP_LL = 2'd0;
  localparam step_t STEP_HL = 2'd1;
  localparam step_t STEP_LH = 2'd2;
  localparam step_t STEP_HH = 2'd3;

  // Quadrant weight: low*low sits at bit 0, the cross terms at h, high*high at 2h.
  function automatic int unsigned step_shift(input step_t s, input int unsigned h);
    case (s)
      STEP_LL:          return 0;
      STEP_HL, STEP_LH: return h;
      default:          return 2 * h;
    endcase
  endfunction

endpackage

// File: rtl/vedic_core_hxh.sv
// Purely combinational W x W -> 2W Vedic multiplier, built recursively from
// four W/2 cores down to a 2x2 Urdhva-Tiryagbhyam leaf.
module vedic_core_hxh #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  if (W == 2) begin : g_leaf
    logic t_ab, t_ba, c1, t_hh;
    assign t_ab = a[1] & b[0];
    assign t_ba = a[0] & b[1];
    assign c1   = t_ab & t_ba;
    assign t_hh = a[1] & b[1];
    assign p    = {t_hh & c1, t_hh ^ c1, t_ab ^ t_ba, a[0] & b[0]};
  end else begin : g_split
    localparam int HW = W / 2;
    logic [W-1:0] ll, hl, lh, hh;

    vedic_core_hxh #(.W(HW)) u_ll (.a(a[HW-1:0]), .b(b[HW-1:0]), .p(ll));
    vedic_core_hxh #(.W(HW)) u_hl (.a(a[W-1:HW]), .b(b[HW-1:0]), .p(hl));
    vedic_core_hxh #(.W(HW)) u_lh (.a(a[HW-1:0]), .b(b[W-1:HW]), .p(lh));
    vedic_core_hxh #(.W(HW)) u_hh (.a(a[W-1:HW]), .b(b[W-1:HW]), .p(hh));

    // Cross terms land at weight HW; the outer quadrants concatenate without overlap.
    assign p = {hh, ll}
             + {{HW{1'b0}}, hl, {HW{1'b0}}}
             + {{HW{1'b0}}, lh, {HW{1'b0}}};
  end

endmodule

// File: rtl/vedic_mul_iter.sv
// Iterative N x N Vedic multiplier: one shared H x H core, one quadrant per cycle.
// Optional approximate mode (drops AL*BL) enabled by VEDIC_MUL_ITER_APPROX_EN.
module vedic_mul_iter
  import vedic_mul_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           out_approx
);

  localparam int unsigned H = N / 2;

  if (N != 8 && N != 16 && N != 32 && N != 64) begin : g_bad_n
    $error("vedic_mul_iter: N must be a power of two in 8..64");
  end

  state_t         state, state_n;
  step_t          step;
  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] acc, acc_next, addend;
  logic [H-1:0]   core_a, core_b;
  logic [N-1:0]   prod;
  logic           accept;
  logic           approx_q;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // step[0] selects the A half, step[1] the B half: LL, HL, LH, HH.
  assign core_a = step[0] ? a_q[N-1:H] : a_q[H-1:0];
  assign core_b = step[1] ? b_q[N-1:H] : b_q[H-1:0];

  vedic_core_hxh #(.W(H)) u_core (.a(core_a), .b(core_b), .p(prod));

  always_comb begin
    addend = {{N{1'b0}}, prod} << step_shift(step, H);
`ifdef VEDIC_MUL_ITER_APPROX_EN
    if (step == STEP_LL && approx_q) addend = '0;
`endif
  end

  assign acc_next = acc + addend;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = CALC;
      CALC:    if (step == STEP_HH) state_n = DONE;
      DONE:    if (out_ready) state_n = accept ? CALC : IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef VEDIC_MUL_ITER_APPROX_EN
  logic out_approx_q;
  assign out_approx = out_approx_q;
`else
  logic unused_approx;
  assign unused_approx = approx;
  assign out_approx    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= STEP_LL;
      acc      <= '0;
      out      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
`ifdef VEDIC_MUL_ITER_APPROX_EN
      out_approx_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        acc      <= '0;
        step     <= STEP_LL;
`ifdef VEDIC_MUL_ITER_APPROX_EN
        approx_q <= approx;
`else
        approx_q <= 1'b0;
`endif
      end else if (state == CALC) begin
        acc  <= acc_next;
        step <= step + 2'd1;
        // out is only written here, so it stays frozen through any DONE stall.
        if (step == STEP_HH) begin
          out <= acc_next;
`ifdef VEDIC_MUL_ITER_APPROX_EN
          out_approx_q <= approx_q;
`endif
        end
      end
    end
  end

endmodule
